// File: rtl/fmt_switch_ctrl_pkg.sv
// fmt_switch_ctrl_pkg: shared audio control encodings, format count and default timing parameters
package fmt_switch_ctrl_pkg;
  typedef enum logic [6:0] {
    S_RUN    = 7'b0000001,
    S_MUTE   = 7'b0000010,
    S_STOP   = 7'b0000100,
    S_LOAD   = 7'b0001000,
    S_SETTLE = 7'b0010000,
    S_START  = 7'b0100000,
    S_UNMUTE = 7'b1000000
  } state_e;
  localparam int unsigned NUM_FMT_DEF       = 6;
  localparam int unsigned SETTLE_CYCLES_DEF = 1024;
  localparam int unsigned MUTE_FRAMES_DEF   = 2;
  localparam int unsigned FRAME_TIMEOUT_DEF = 65535;
  function automatic int unsigned cnt_w(input int unsigned max_v);
    return (max_v > 0) ? $clog2(max_v + 1) : 1;
  endfunction
endpackage

// File: rtl/fmt_switch_ctrl_frame_wait_cnt.sv
// frame_wait_cnt: counts frame_end pulses, treating a silent timeout window as one frame
module frame_wait_cnt
  import fmt_switch_ctrl_pkg::*;
#(
  parameter int unsigned FRAMES  = MUTE_FRAMES_DEF,
  parameter int unsigned TIMEOUT = FRAME_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic frame_end_i,
  output logic done_o
);
  localparam int unsigned FW = cnt_w(FRAMES);
  localparam int unsigned TW = cnt_w(TIMEOUT);
  logic [FW-1:0] fr_q, fr_d;
  logic [TW-1:0] to_q, to_d;
  logic tick;
  // a frame counts on a pulse or when the gap since the last count hits the timeout
  always_comb begin
    tick = frame_end_i || (TIMEOUT == 0) || (32'(to_q) + 32'd1 >= TIMEOUT);
    done_o = en_i && (32'(fr_q) + 32'(tick) >= FRAMES);
    fr_d = (en_i && !done_o) ? fr_q + FW'(tick) : '0;
    to_d = (en_i && !tick) ? to_q + TW'(1) : '0;
  end
  // frame and gap counters, cleared whenever the wait is inactive
  always_ff @(posedge clk) begin
    if (rst) begin
      fr_q <= '0;
      to_q <= '0;
    end else begin
      fr_q <= fr_d;
      to_q <= to_d;
    end
  end
endmodule

// File: rtl/fmt_switch_ctrl.sv
// fmt_switch_ctrl: sequences a glitch-free I2S format change (mute, stop, load divider, settle, restart, unmute)
module fmt_switch_ctrl
  import fmt_switch_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int unsigned MUTE_FRAMES   = MUTE_FRAMES_DEF,
  parameter int unsigned FRAME_TIMEOUT = FRAME_TIMEOUT_DEF,
  parameter int unsigned NUM_FMT       = NUM_FMT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] clk_sel_i,
  input  logic       frame_end_i,
  output logic [2:0] div_sel_o,
  output logic       i2s_en_o,
  output logic       mute_o,
  output logic       busy_o,
  output logic       fmt_err_o
);
  localparam int unsigned SW = cnt_w(SETTLE_CYCLES);
  state_e state_q, state_d;
  logic [2:0] target_q, div_q;
  logic [SW-1:0] set_q;
  logic err_q, sel_ok, settle_done, wait_en, wait_done;
  assign sel_ok = 32'(clk_sel_i) < NUM_FMT;
  assign settle_done = (SETTLE_CYCLES == 0) || (32'(set_q) + 32'd1 >= SETTLE_CYCLES);
  frame_wait_cnt #(
    .FRAMES (MUTE_FRAMES),
    .TIMEOUT(FRAME_TIMEOUT)
  ) u_wait (
    .clk        (clk),
    .rst        (rst),
    .en_i       (wait_en),
    .frame_end_i(frame_end_i),
    .done_o     (wait_done)
  );
  // state register; reset restarts the divider from a stopped, muted state
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_LOAD;
    else state_q <= state_d;
  end
  // target latch, divider load, settle counter and sticky format error
  always_ff @(posedge clk) begin
    if (rst) begin
      target_q <= sel_ok ? clk_sel_i : '0;
      div_q <= '0;
      set_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == S_RUN && sel_ok && clk_sel_i != div_q) target_q <= clk_sel_i;
      if (state_q == S_LOAD) div_q <= target_q;
      set_q <= (state_q == S_SETTLE && !settle_done) ? set_q + SW'(1) : '0;
      err_q <= err_q || (state_q == S_RUN && !sel_ok);
    end
  end
  // next-state sequencing of the format switch
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:    state_d = (sel_ok && clk_sel_i != div_q) ? S_MUTE : S_RUN;
      S_MUTE:   state_d = wait_done ? S_STOP : S_MUTE;
      S_STOP:   state_d = S_LOAD;
      S_LOAD:   state_d = S_SETTLE;
      S_SETTLE: state_d = settle_done ? S_START : S_SETTLE;
      S_START:  state_d = S_UNMUTE;
      S_UNMUTE: state_d = wait_done ? S_RUN : S_UNMUTE;
      default:  state_d = S_LOAD;
    endcase
  end
  // outputs decoded from state; mute covers every non-running state
  always_comb begin
    busy_o = state_q != S_RUN;
    mute_o = busy_o;
    i2s_en_o = state_q inside {S_RUN, S_MUTE, S_START, S_UNMUTE};
    wait_en = state_q inside {S_MUTE, S_UNMUTE};
    div_sel_o = div_q;
    fmt_err_o = err_q;
  end
endmodule

// File: tb/tb_fmt_switch_ctrl.sv
// tb_fmt_switch_ctrl: directed vectors plus randomized run against a phase-level reference model
module tb_fmt_switch_ctrl;
  localparam int S = 16, MF = 2, TO = 100, NF = 6, N = 4000;
  localparam int SX = (S == 0) ? 1 : S;
  logic clk = 1'b0, rst = 1'b1, fe = 1'b0;
  logic [2:0] sel = 3'd0;
  logic [2:0] div;
  logic en, mute, busy, err;
  int checks = 0, failures = 0, cyc = 0, period = 0;
  int n, np, anyen;
  int rs[N], rf[N], e_div[N], e_en[N], e_mute[N], e_busy[N], e_err[N];
  typedef struct {int s; int f; int div; int en; int mute; int busy; int err;} vec_t;
  vec_t tbl[6];
  logic [2:0] pdiv = 3'd0;
  logic pen = 1'b0, prst = 1'b1;

  fmt_switch_ctrl #(
    .SETTLE_CYCLES(S),
    .MUTE_FRAMES  (MF),
    .FRAME_TIMEOUT(TO),
    .NUM_FMT      (NF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_sel_i  (sel),
    .frame_end_i(fe),
    .div_sel_o  (div),
    .i2s_en_o   (en),
    .mute_o     (mute),
    .busy_o     (busy),
    .fmt_err_o  (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    checks++;
    if (!prst && div != pdiv && (pen || en)) begin
      failures++;
      $display("FAIL div_change_while_enabled: div %0d->%0d with i2s_en %0b/%0b", pdiv, div, pen, en);
    end
    pdiv = div;
    pen = en;
    prst = rst;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [2:0] s, input logic f);
    rst = r;
    sel = s;
    fe = f;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic stepp(input logic [2:0] s);
    step(1'b0, s, period != 0 && (cyc % period) == period - 1);
  endtask

  task automatic wait_idle(input logic [2:0] s, input string name);
    int k = 0;
    do begin
      stepp(s);
      k++;
    end while (busy && k < 3000);
    chk({name, " busy_low_reached"}, int'(busy), 0);
  endtask

  function automatic void put(int a, int b, int d, int en_x, int mu, int bu, int er);
    for (int k = a; k <= b && k < N; k++) begin
      if (k < 0) continue;
      e_div[k] = d;
      e_en[k] = en_x;
      e_mute[k] = mu;
      e_busy[k] = bu;
      e_err[k] = er;
    end
  endfunction

  // edge at which MF frames have been counted, starting the count at edge a
  function automatic int wait_end(int a);
    int c = 0, gap = 0;
    if (MF == 0) return a;
    for (int u = a; u < N; u++) begin
      if (rf[u] != 0 || gap + 1 >= TO) begin
        c++;
        gap = 0;
      end else gap++;
      if (c >= MF) return u;
    end
    return N + 10;
  endfunction

  // expected outputs after each edge, derived from phase durations
  function automatic void build_model();
    int d = 0, er = 0, tgt, l = 0, w, t, u;
    tgt = (rs[0] < NF) ? rs[0] : 0;
    while (l < N) begin
      put(l, l, d, 0, 1, 1, er);
      d = tgt;
      put(l + 1, l + SX, d, 0, 1, 1, er);
      put(l + 1 + SX, l + 1 + SX, d, 1, 1, 1, er);
      w = wait_end(l + 3 + SX);
      put(l + 2 + SX, w - 1, d, 1, 1, 1, er);
      put(w, w, d, 1, 0, 0, er);
      t = w + 1;
      l = N;
      while (t < N) begin
        if (rs[t] >= NF) begin
          er = 1;
          put(t, t, d, 1, 0, 0, er);
        end else if (rs[t] != d) begin
          tgt = rs[t];
          u = wait_end(t + 1);
          put(t, u - 1, d, 1, 1, 1, er);
          put(u, u, d, 0, 1, 1, er);
          l = u + 1;
          break;
        end else put(t, t, d, 1, 0, 0, er);
        t++;
      end
    end
  endfunction

  initial begin
    // startup after reset with clk_sel=3, frames every 64 cycles
    period = 64;
    step(1'b1, 3'd3, 1'b0);
    chk("rst i2s_en", int'(en), 0);
    chk("rst mute", int'(mute), 1);
    chk("rst busy", int'(busy), 1);
    chk("rst div_sel", int'(div), 0);
    chk("rst fmt_err", int'(err), 0);
    stepp(3'd3);
    chk("startup div_sel loaded", int'(div), 3);
    chk("startup settle en", int'(en), 0);
    anyen = 0;
    for (int i = 0; i < SX - 1; i++) begin
      stepp(3'd3);
      anyen |= int'(en);
    end
    chk("startup en held low during settle", anyen, 0);
    stepp(3'd3);
    chk("startup en after settle", int'(en), 1);
    chk("startup still muted", int'(mute), 1);
    np = 0;
    n = 0;
    do begin
      stepp(3'd3);
      np += int'(fe);
      n++;
    end while (busy && n < 1000);
    chk("startup unmute frames", np, MF);
    chk("startup mute released", int'(mute), 0);
    chk("startup busy low", int'(busy), 0);
    // table of single-cycle behaviours in S_RUN
    tbl[0] = '{s:3, f:0, div:3, en:1, mute:0, busy:0, err:0};
    tbl[1] = '{s:3, f:1, div:3, en:1, mute:0, busy:0, err:0};
    tbl[2] = '{s:7, f:0, div:3, en:1, mute:0, busy:0, err:1};
    tbl[3] = '{s:6, f:0, div:3, en:1, mute:0, busy:0, err:1};
    tbl[4] = '{s:3, f:0, div:3, en:1, mute:0, busy:0, err:1};
    tbl[5] = '{s:1, f:0, div:3, en:1, mute:1, busy:1, err:1};
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 3'(tbl[i].s), tbl[i].f != 0);
      chk($sformatf("vec%0d div_sel", i), int'(div), tbl[i].div);
      chk($sformatf("vec%0d i2s_en", i), int'(en), tbl[i].en);
      chk($sformatf("vec%0d mute", i), int'(mute), tbl[i].mute);
      chk($sformatf("vec%0d busy", i), int'(busy), tbl[i].busy);
      chk($sformatf("vec%0d fmt_err", i), int'(err), tbl[i].err);
    end
    // switch 3->1: stop after two frames, load one cycle after stop
    np = 0;
    n = 0;
    do begin
      stepp(3'd1);
      np += int'(fe);
      n++;
    end while (en && n < 1000);
    chk("switch frames before stop", np, MF);
    chk("switch stop div_sel", int'(div), 3);
    stepp(3'd1);
    chk("switch load en", int'(en), 0);
    stepp(3'd1);
    chk("switch div_sel new", int'(div), 1);
    chk("switch div_sel en", int'(en), 0);
    wait_idle(3'd1, "switch");
    chk("switch final div_sel", int'(div), 1);
    chk("switch fmt_err sticky", int'(err), 1);
    // no frames at all: timeout counts each missing frame
    period = 0;
    step(1'b0, 3'd2, 1'b0);
    chk("timeout mute entered", int'(busy), 1);
    n = 0;
    do begin
      stepp(3'd2);
      n++;
    end while (en && n < 1000);
    chk("timeout cycles in mute", n, 2 * TO);
    wait_idle(3'd2, "timeout");
    chk("timeout final div_sel", int'(div), 2);
    // clk_sel change during settle is deferred to a second sequence
    step(1'b0, 3'd1, 1'b0);
    n = 0;
    do begin
      stepp(3'd1);
      n++;
    end while (en && n < 1000);
    stepp(3'd1);
    stepp(3'd1);
    chk("defer settle div_sel", int'(div), 1);
    stepp(3'd4);
    wait_idle(3'd4, "defer first");
    chk("defer first div_sel", int'(div), 1);
    wait_idle(3'd4, "defer second");
    chk("defer second div_sel", int'(div), 4);
    // reset during S_UNMUTE
    period = 64;
    stepp(3'd5);
    n = 0;
    do begin
      stepp(3'd5);
      n++;
    end while (en && n < 1000);
    n = 0;
    do begin
      stepp(3'd5);
      n++;
    end while (!en && n < 200);
    stepp(3'd5);
    chk("unmute div_sel", int'(div), 5);
    chk("unmute mute", int'(mute), 1);
    chk("unmute en", int'(en), 1);
    step(1'b1, 3'd2, 1'b0);
    chk("midrst i2s_en", int'(en), 0);
    chk("midrst mute", int'(mute), 1);
    chk("midrst div_sel", int'(div), 0);
    chk("midrst busy", int'(busy), 1);
    chk("midrst fmt_err cleared", int'(err), 0);
    stepp(3'd2);
    chk("midrst reload div_sel", int'(div), 2);
    wait_idle(3'd2, "midrst");
    chk("midrst final div_sel", int'(div), 2);
    // randomized run against the phase model, starting with a reset
    begin
      int hold = 0, cur = 0, dense = 1;
      for (int k = 0; k < N; k++) begin
        if (k % 500 == 0) dense = ($urandom_range(0, 2) != 0) ? 1 : 0;
        if (hold == 0) begin
          cur = int'($urandom_range(0, 7));
          hold = int'($urandom_range(50, 400));
        end
        hold--;
        rs[k] = cur;
        rf[k] = (dense != 0 && $urandom_range(0, 29) == 0) ? 1 : 0;
      end
    end
    build_model();
    for (int k = 0; k < N; k++) begin
      step(k == 0, 3'(rs[k]), rf[k] != 0);
      chk($sformatf("rand%0d {div,en,mute,busy,err}", k),
          int'({div, en, mute, busy, err}),
          (e_div[k] << 4) | (e_en[k] << 3) | (e_mute[k] << 2) | (e_busy[k] << 1) | e_err[k]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
